// File: rtl/demux_1_to_4_buf.sv
// Buffered 1-to-4 demultiplexer: one valid/ready producer stream is steered by
// Select into one of four independent channel FIFOs, each with its own valid/ready sink.
module demux_1_to_4_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        Select,
  input  logic [DATA_W-1:0] Data_i,
  input  logic              Valid_i,
  output logic              Ready_o,
  output logic [DATA_W-1:0] Data_o1,
  output logic [DATA_W-1:0] Data_o2,
  output logic [DATA_W-1:0] Data_o3,
  output logic [DATA_W-1:0] Data_o4,
  output logic [3:0]        Valid_o,
  input  logic [3:0]        Ready_i,
  output logic              Empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0]     w_count [4];
  logic [DATA_W-1:0] w_head  [4];
  logic [3:0]        w_push;
  logic [3:0]        w_pop;

  // Input-side backpressure looks only at the selected channel's occupancy.
  always_comb begin
    w_push  = 4'b0000;
    case (Select)
      2'b00:   Ready_o = (w_count[0] != FULL_CNT);
      2'b01:   Ready_o = (w_count[1] != FULL_CNT);
      2'b10:   Ready_o = (w_count[2] != FULL_CNT);
      2'b11:   Ready_o = (w_count[3] != FULL_CNT);
      default: Ready_o = 1'b0;
    endcase
    if (Valid_i && Ready_o) begin
      w_push[Select] = 1'b1;
    end else begin
      w_push = 4'b0000;
    end
  end

  assign w_pop = Valid_o & Ready_i;

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_ch
      logic [PW-1:0]     r_wr_ptr;
      logic [PW-1:0]     r_rd_ptr;
      logic [CW-1:0]     r_count;
      logic [DATA_W-1:0] r_mem [DEPTH];

      // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count as-is.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push[k]) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
          end
          if (w_pop[k]) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
          end
          case ({w_push[k], w_pop[k]})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
          endcase
        end
      end

      // Payload storage needs no reset: the head is masked to zero while empty.
      always_ff @(posedge clk) begin
        if (w_push[k]) begin
          r_mem[r_wr_ptr] <= Data_i;
        end
      end

      assign w_count[k] = r_count;
      assign Valid_o[k] = (r_count != '0);
      assign w_head[k]  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    end
  endgenerate

  assign Data_o1 = w_head[0];
  assign Data_o2 = w_head[1];
  assign Data_o3 = w_head[2];
  assign Data_o4 = w_head[3];
  assign Empty_o = ~|Valid_o;

endmodule

// File: tb/tb_demux_1_to_4_buf.sv
// Directed self-checking bench for demux_1_to_4_buf with hand-computed expectations.
module tb_demux_1_to_4_buf;

  logic        clk;
  logic        reset;
  logic [1:0]  Select;
  logic [31:0] Data_i;
  logic        Valid_i;
  logic        Ready_o;
  logic [31:0] Data_o1, Data_o2, Data_o3, Data_o4;
  logic [3:0]  Valid_o;
  logic [3:0]  Ready_i;
  logic        Empty_o;

  int checks   = 0;
  int failures = 0;

  demux_1_to_4_buf #(.DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .Select(Select), .Data_i(Data_i), .Valid_i(Valid_i),
    .Ready_o(Ready_o), .Data_o1(Data_o1), .Data_o2(Data_o2), .Data_o3(Data_o3),
    .Data_o4(Data_o4), .Valid_o(Valid_o), .Ready_i(Ready_i), .Empty_o(Empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    Valid_i = 1'b1;
    Select  = 2'b00;
    Data_i  = 32'hDEAD_BEEF;
    Ready_i = 4'b0000;
    tick();
    tick();
    // 1. reset state with Valid_i held high
    check("rst_valid", {28'd0, Valid_o}, 32'h0);
    check("rst_empty", {31'd0, Empty_o}, 32'h1);
    check("rst_ready", {31'd0, Ready_o}, 32'h1);
    check("rst_d1", Data_o1, 32'h0);
    check("rst_d2", Data_o2, 32'h0);
    check("rst_d3", Data_o3, 32'h0);
    check("rst_d4", Data_o4, 32'h0);
    reset   = 1'b0;
    Valid_i = 1'b0;
    Select  = 2'b11;
    Data_i  = 32'h0000_BAD0;
    tick();
    check("idle_ignored", {28'd0, Valid_o}, 32'h0);

    // 2. two pushes to channel 1
    Select  = 2'b00;
    Valid_i = 1'b1;
    Data_i  = 32'hA1;
    tick();
    check("lat_valid", {28'd0, Valid_o}, 32'h1);
    check("lat_d1", Data_o1, 32'hA1);
    Data_i = 32'hA2;
    tick();
    Valid_i = 1'b0;
    check("t2_d1", Data_o1, 32'hA1);
    check("t2_valid", {28'd0, Valid_o}, 32'h1);
    check("t2_ready_s0", {31'd0, Ready_o}, 32'h0);
    Select = 2'b01;
    #1;
    check("t2_ready_s1", {31'd0, Ready_o}, 32'h1);

    // 3. drain channel 1
    Ready_i = 4'b0001;
    tick();
    check("t3_d1", Data_o1, 32'hA2);
    check("t3_valid1", {28'd0, Valid_o}, 32'h1);
    tick();
    Ready_i = 4'b0000;
    check("t3_valid0", {28'd0, Valid_o}, 32'h0);
    check("t3_empty", {31'd0, Empty_o}, 32'h1);
    check("t3_d1zero", Data_o1, 32'h0);

    // 4. push and pop together on channel 3
    Select  = 2'b10;
    Valid_i = 1'b1;
    Data_i  = 32'hC0;
    tick();
    Data_i  = 32'hC3;
    Ready_i = 4'b0100;
    check("t4_ready_pre", {31'd0, Ready_o}, 32'h1);
    tick();
    Valid_i = 1'b0;
    Ready_i = 4'b0000;
    check("t4_valid", {28'd0, Valid_o}, 32'h4);
    check("t4_d3", Data_o3, 32'hC3);
    check("t4_count1", {31'd0, Ready_o}, 32'h1);
    Ready_i = 4'b0100;
    tick();
    Ready_i = 4'b0000;
    check("t4_drained", {28'd0, Valid_o}, 32'h0);

    // 5. all four channels pop in one cycle
    Valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Select = 2'(i);
      Data_i = 32'h11 * (i + 1);
      tick();
    end
    Valid_i = 1'b0;
    check("t5_valid", {28'd0, Valid_o}, 32'hF);
    check("t5_empty", {31'd0, Empty_o}, 32'h0);
    check("t5_d1", Data_o1, 32'h11);
    check("t5_d2", Data_o2, 32'h22);
    check("t5_d3", Data_o3, 32'h33);
    check("t5_d4", Data_o4, 32'h44);
    Ready_i = 4'b1111;
    tick();
    Ready_i = 4'b0000;
    check("t5_valid0", {28'd0, Valid_o}, 32'h0);
    check("t5_empty1", {31'd0, Empty_o}, 32'h1);

    // full channel stalls even while being drained
    Select  = 2'b01;
    Valid_i = 1'b1;
    Data_i  = 32'h61;
    tick();
    Data_i  = 32'h62;
    tick();
    check("full_ready", {31'd0, Ready_o}, 32'h0);
    Data_i  = 32'h63;
    Ready_i = 4'b0010;
    check("stall_ready", {31'd0, Ready_o}, 32'h0);
    tick();
    Valid_i = 1'b0;
    Ready_i = 4'b0000;
    check("stall_d2", Data_o2, 32'h62);
    check("stall_count1", {31'd0, Ready_o}, 32'h1);
    Valid_i = 1'b1;
    Data_i  = 32'h64;
    tick();
    Valid_i = 1'b0;
    check("refill_full", {31'd0, Ready_o}, 32'h0);
    check("refill_valid", {28'd0, Valid_o}, 32'h2);

    // 6. asynchronous reset with channel 2 full
    #1;
    reset = 1'b1;
    #1;
    check("arst_valid", {28'd0, Valid_o}, 32'h0);
    check("arst_empty", {31'd0, Empty_o}, 32'h1);
    check("arst_d2", Data_o2, 32'h0);
    check("arst_ready", {31'd0, Ready_o}, 32'h1);
    #1;
    reset   = 1'b0;
    Valid_i = 1'b1;
    Select  = 2'b01;
    Data_i  = 32'h55;
    tick();
    Valid_i = 1'b0;
    check("post_d2", Data_o2, 32'h55);
    check("post_valid", {28'd0, Valid_o}, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
